// File: rtl/wimax_pkg.sv
// -----------------------------------------------------------------------------
// wimax_pkg
// Shared constants and helpers for the WiMAX transmit-chain FEC blocks.
//   FEC_BLOCK_IN / FEC_BLOCK_OUT : uncoded / coded bits per FEC block
//   FEC_G1 / FEC_G2              : K=7 generator polynomials (octal 171 / 133)
//   enc_state_t                  : encode FSM state type
//   cc_tap()                     : one generator output for current bit + state
//   sr_from_tail()               : tail-biting preload of the shift register
// -----------------------------------------------------------------------------
package wimax_pkg;

   localparam int FEC_BLOCK_IN  = 96;
   localparam int FEC_BLOCK_OUT = 2 * FEC_BLOCK_IN;
   localparam int FEC_SR_W      = 6;

   localparam logic [6:0] FEC_G1 = 7'o171;
   localparam logic [6:0] FEC_G2 = 7'o133;

   typedef enum logic {
      ENC_IDLE,
      ENC_ENCODE
   } enc_state_t;

   // sr[0] holds s1 (most recent bit), sr[5] holds s6 (oldest).
   // The generator MSB taps the current bit u, then s1..s6 going down.
   function automatic logic cc_tap(input logic [6:0] g,
                                   input logic u,
                                   input logic [FEC_SR_W-1:0] sr);
      return ^(g & {u, sr[0], sr[1], sr[2], sr[3], sr[4], sr[5]});
   endfunction

   // tail holds buffer bits [95:90] (tail[5] = bit 95). Bit 95 becomes s1,
   // bit 90 becomes s6, so the vector is bit-reversed into sr.
   function automatic logic [FEC_SR_W-1:0] sr_from_tail(input logic [FEC_SR_W-1:0] tail);
      logic [FEC_SR_W-1:0] r;
      r = '0;
      for (int unsigned k = 0; k < FEC_SR_W; k++) begin
         r[k] = tail[FEC_SR_W-1-k];
      end
      return r;
   endfunction

endpackage

// File: rtl/fec_in_pingpong.sv
// -----------------------------------------------------------------------------
// fec_in_pingpong
// Double-buffered serial input store for the convolutional encoder.
// Block k+1 is written into one buffer while block k is read from the other.
// Ports:
//   clk, resetN        clock, asynchronous active-low reset
//   d_in, valid_in     serial uncoded bit and its valid
//   ready_in           high while the buffer being written is not full
//   full[1:0]          per-buffer "complete block waiting/being encoded" flags
//   rd_sel, rd_idx     read port: buffer select and bit index -> rd_bit
//   tail_sel           buffer whose bits [BLOCK_IN-1 -: 6] appear on tail
//   free               strobe: clear full[rd_sel] at this edge
// -----------------------------------------------------------------------------
module fec_in_pingpong
   import wimax_pkg::*;
#(
   parameter int BLOCK_IN = FEC_BLOCK_IN,
   parameter int CNT_W    = 8,
   parameter int IDX_W    = $clog2(BLOCK_IN)
)(
   input  logic                clk,
   input  logic                resetN,
   input  logic                d_in,
   input  logic                valid_in,
   output logic                ready_in,
   output logic [1:0]          full,
   input  logic                rd_sel,
   input  logic [IDX_W-1:0]    rd_idx,
   output logic                rd_bit,
   input  logic                tail_sel,
   output logic [FEC_SR_W-1:0] tail,
   input  logic                free
);

   localparam logic [CNT_W-1:0] LAST_IN = CNT_W'(BLOCK_IN - 1);

   logic [BLOCK_IN-1:0] mem [2];
   logic [CNT_W-1:0]    in_cnt;
   logic                wr_sel;
   logic                accept;
   logic                last_bit;

   always_comb begin
      ready_in = !full[wr_sel];
      accept   = valid_in && ready_in;
      last_bit = (in_cnt == LAST_IN);
      rd_bit   = mem[rd_sel][rd_idx];
      tail     = mem[tail_sel][BLOCK_IN-1 -: FEC_SR_W];
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         in_cnt <= '0;
         wr_sel <= 1'b0;
         full   <= '0;
      end else begin
         if (accept) begin
            if (last_bit) begin
               in_cnt <= '0;
               wr_sel <= ~wr_sel;
            end else begin
               in_cnt <= in_cnt + 1'b1;
            end
         end
         // The buffer being freed is always the one being read, which is full,
         // so it can never be the buffer being written (which is not full):
         // both updates can take effect on the same edge.
         if (free) begin
            full[rd_sel] <= 1'b0;
         end
         if (accept && last_bit) begin
            full[wr_sel] <= 1'b1;
         end
      end
   end

   // Data storage needs no reset: full[] gates every read.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem[wr_sel][in_cnt[IDX_W-1:0]] <= d_in;
      end
   end

endmodule

// File: rtl/fec_cc_encoder.sv
// -----------------------------------------------------------------------------
// fec_cc_encoder
// Rate-1/2, K=7 tail-biting convolutional encoder (WiMAX). Loads BLOCK_IN
// uncoded bits serially, then emits 2*BLOCK_IN coded bits as one unbroken
// burst in the order X0 Y0 X1 Y1 ... Consecutive ready blocks are emitted
// back-to-back with no idle cycle.
// Ports:
//   clk, resetN        clock, asynchronous active-low reset
//   d_in, valid_in     uncoded serial bit from the randomizer and its valid
//   ready_in           encoder can accept d_in this cycle
//   q, valid_out       coded serial bit (0 when not valid) and its valid
//   err_drop           (FEC_ERR_EN only) sticky: valid_in seen with ready_in=0
// Optional feature macro: FEC_ERR_EN
// -----------------------------------------------------------------------------
module fec_cc_encoder
   import wimax_pkg::*;
#(
   parameter int BLOCK_IN = FEC_BLOCK_IN,
   parameter int CNT_W    = 8
)(
   input  logic clk,
   input  logic resetN,
   input  logic d_in,
   input  logic valid_in,
   output logic ready_in,
   output logic q,
   output logic valid_out
`ifdef FEC_ERR_EN
   ,
   output logic err_drop
`endif
);

   localparam int               IDX_W    = $clog2(BLOCK_IN);
   localparam logic [CNT_W-1:0] LAST_OUT = CNT_W'(2 * BLOCK_IN - 1);

   enc_state_t          state, state_nxt;
   logic [CNT_W-1:0]    out_cnt, cnt_nxt;
   logic [FEC_SR_W-1:0] sr, sr_nxt;
   logic                rd_sel, rd_sel_nxt;
   logic                tail_sel;
   logic                free;
   logic [1:0]          full;
   logic                rd_bit;
   logic [FEC_SR_W-1:0] tail;
   logic                x_bit, y_bit;

   fec_in_pingpong #(
      .BLOCK_IN (BLOCK_IN),
      .CNT_W    (CNT_W),
      .IDX_W    (IDX_W)
   ) u_in (
      .clk      (clk),
      .resetN   (resetN),
      .d_in     (d_in),
      .valid_in (valid_in),
      .ready_in (ready_in),
      .full     (full),
      .rd_sel   (rd_sel),
      .rd_idx   (out_cnt[IDX_W:1]),
      .rd_bit   (rd_bit),
      .tail_sel (tail_sel),
      .tail     (tail),
      .free     (free)
   );

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state   <= ENC_IDLE;
         out_cnt <= '0;
         sr      <= '0;
         rd_sel  <= 1'b0;
      end else begin
         state   <= state_nxt;
         out_cnt <= cnt_nxt;
         sr      <= sr_nxt;
         rd_sel  <= rd_sel_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = out_cnt;
      sr_nxt     = sr;
      rd_sel_nxt = rd_sel;
      tail_sel   = rd_sel;
      free       = 1'b0;
      unique case (state)
         ENC_IDLE: begin
            if (full[rd_sel]) begin
               state_nxt = ENC_ENCODE;
               cnt_nxt   = '0;
               sr_nxt    = sr_from_tail(tail);
            end
         end
         ENC_ENCODE: begin
            cnt_nxt = out_cnt + 1'b1;
            if (out_cnt[0]) begin
               sr_nxt = {sr[FEC_SR_W-2:0], rd_bit};
            end
            if (out_cnt == LAST_OUT) begin
               free       = 1'b1;
               rd_sel_nxt = ~rd_sel;
               cnt_nxt    = '0;
               // Preload comes from the buffer about to be selected, so the
               // tail read port is steered ahead of rd_sel itself.
               tail_sel   = ~rd_sel;
               if (full[~rd_sel]) begin
                  sr_nxt = sr_from_tail(tail);
               end else begin
                  state_nxt = ENC_IDLE;
               end
            end
         end
         default: state_nxt = ENC_IDLE;
      endcase
   end

   always_comb begin
      valid_out = (state == ENC_ENCODE);
      x_bit     = cc_tap(FEC_G1, rd_bit, sr);
      y_bit     = cc_tap(FEC_G2, rd_bit, sr);
      q         = valid_out & (out_cnt[0] ? y_bit : x_bit);
   end

`ifdef FEC_ERR_EN
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         err_drop <= 1'b0;
      end else if (valid_in && !ready_in) begin
         err_drop <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_fec_cc_encoder.sv
// -----------------------------------------------------------------------------
// tb_fec_cc_encoder
// Directed and randomized checks of fec_cc_encoder against a tail-biting
// reference computed directly from u[n-k] (indices modulo the block length).
// -----------------------------------------------------------------------------
module tb_fec_cc_encoder;

   localparam int N = 96;
   localparam int M = 192;

   logic clk = 1'b0;
   logic resetN = 1'b0;
   logic d_in = 1'b0;
   logic valid_in = 1'b0;
   logic ready_in, q, valid_out;
`ifdef FEC_ERR_EN
   logic err_drop;
`endif

   fec_cc_encoder dut (
      .clk       (clk),
      .resetN    (resetN),
      .d_in      (d_in),
      .valid_in  (valid_in),
      .ready_in  (ready_in),
      .q         (q),
      .valid_out (valid_out)
`ifdef FEC_ERR_EN
      ,
      .err_drop  (err_drop)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every valid output bit with the edge count of its cycle.
   logic cap_q[$];
   int   cap_cyc[$];
   int   stall_cnt = 0;
   always @(negedge clk) begin
      if (valid_out) begin
         cap_q.push_back(q);
         cap_cyc.push_back(cyc);
      end
      if (valid_in && !ready_in) stall_cnt = stall_cnt + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [M-1:0] obs, input logic [M-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [M-1:0] ref_enc(input logic [N-1:0] u);
      logic [M-1:0] r;
      r = '0;
      for (int n = 0; n < N; n++) begin
         r[2*n]   = u[n] ^ u[(n+N-1)%N] ^ u[(n+N-2)%N] ^ u[(n+N-3)%N] ^ u[(n+N-6)%N];
         r[2*n+1] = u[n] ^ u[(n+N-2)%N] ^ u[(n+N-3)%N] ^ u[(n+N-5)%N] ^ u[(n+N-6)%N];
      end
      return r;
   endfunction

   function automatic logic [N-1:0] rand_block();
      return {$urandom(), $urandom(), $urandom()};
   endfunction

   // Drives nbits bits of b (bit 0 first), holding each until accepted.
   task automatic send_bits(input logic [N-1:0] b, input int nbits, output int last_edge);
      logic r;
      bit   accepted;
      for (int i = 0; i < nbits; i++) begin
         d_in = b[i];
         valid_in = 1'b1;
         accepted = 1'b0;
         for (int t = 0; t < 1000 && !accepted; t++) begin
            @(negedge clk);
            r = ready_in;
            @(posedge clk);
            #1;
            if (r) accepted = 1'b1;
         end
         if (!accepted) check("accept_timeout", M'(accepted), M'(1));
      end
      valid_in = 1'b0;
      d_in = 1'b0;
      last_edge = cyc;
   endtask

   task automatic wait_caps(input int target, input int budget);
      for (int t = 0; t < budget && cap_q.size() < target; t++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [M-1:0] burst(input int start, input int len);
      logic [M-1:0] v;
      v = '0;
      for (int k = 0; k < len; k++) v[k] = cap_q[start+k];
      return v;
   endfunction

   function automatic int gaps(input int start, input int len);
      int g;
      g = 0;
      for (int k = start; k < start + len - 1; k++)
         if (cap_cyc[k+1] != cap_cyc[k] + 1) g++;
      return g;
   endfunction

   // One isolated block: count, start latency, continuity, data.
   task automatic run_block(input string tag, input logic [N-1:0] b, input logic [M-1:0] exp);
      int base, e;
      base = cap_q.size();
      send_bits(b, N, e);
      wait_caps(base + M, 600);
      idle_cycles(4);
      check({tag, "_count"}, M'(cap_q.size() - base), M'(M));
      if (cap_q.size() - base >= M) begin
         check({tag, "_start"}, M'(cap_cyc[base]), M'(e + 1));
         check({tag, "_gaps"}, M'(gaps(base, M)), M'(0));
         check({tag, "_data"}, burst(base, M), exp);
      end
   endtask

   initial begin
      logic [N-1:0] blk [3];
      logic [M-1:0] exp;
      logic [13:0]  pat14;
      logic [11:0]  pat12;
      int base, e, e2, st0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready_in", M'(ready_in), M'(1));
      check("rst_valid_out", M'(valid_out), M'(0));
      check("rst_q", M'(q), M'(0));
`ifdef FEC_ERR_EN
      check("rst_err_drop", M'(err_drop), M'(0));
`endif
      resetN = 1'b1;
      idle_cycles(2);
      check("idle_valid_out", M'(valid_out), M'(0));

      // All zeros / all ones
      run_block("zeros", '0, '0);
      run_block("ones", '1, '1);

      // Single one at bit 0
      pat14 = 14'b11101111000111;
      exp = '0;
      for (int k = 0; k < 14; k++) exp[k] = pat14[13-k];
      run_block("bit0", N'(1), exp);

      // Single one at bit 95: tail-biting wraps into the start of the burst
      pat12 = 12'b101111000111;
      exp = '0;
      for (int k = 0; k < 12; k++) exp[k] = pat12[11-k];
      exp[190] = 1'b1;
      exp[191] = 1'b1;
      run_block("bit95", {1'b1, {(N-1){1'b0}}}, exp);

      // Random blocks, one at a time
      for (int i = 0; i < 2; i++) begin
         blk[0] = rand_block();
         run_block("rand_single", blk[0], ref_enc(blk[0]));
      end

      // Three blocks with valid_in held high throughout
      for (int i = 0; i < 3; i++) blk[i] = rand_block();
      base = cap_q.size();
      st0 = stall_cnt;
      for (int i = 0; i < 3; i++) send_bits(blk[i], N, e);
      wait_caps(base + 3*M, 1500);
      idle_cycles(4);
      check("cont_count", M'(cap_q.size() - base), M'(3*M));
      check("cont_stalled", M'(stall_cnt > st0), M'(1));
      if (cap_q.size() - base >= 3*M) begin
         check("cont_gaps", M'(gaps(base, 3*M)), M'(0));
         for (int i = 0; i < 3; i++)
            check($sformatf("cont_data%0d", i), burst(base + i*M, M), ref_enc(blk[i]));
      end
`ifdef FEC_ERR_EN
      check("err_set_by_stall", M'(err_drop), M'(1));
`endif

      // Reset during burst at out_cnt=100 with 40 bits of the next block in
      blk[0] = rand_block();
      blk[1] = rand_block();
      base = cap_q.size();
      send_bits(blk[0], N, e);
      send_bits(blk[1], 40, e2);
      for (int t = 0; t < 300 && cyc < e + 101; t++) begin
         @(posedge clk);
         #1;
      end
      resetN = 1'b0;
      #1;
      check("midrst_valid_out", M'(valid_out), M'(0));
      check("midrst_q", M'(q), M'(0));
      check("midrst_ready_in", M'(ready_in), M'(1));
`ifdef FEC_ERR_EN
      check("midrst_err_drop", M'(err_drop), M'(0));
`endif
      check("midrst_count", M'(cap_q.size() - base), M'(100));
      if (cap_q.size() - base >= 100) begin
         exp = ref_enc(blk[0]);
         check("midrst_prefix", M'(burst(base, 100) & {{(M-100){1'b0}}, {100{1'b1}}}),
               M'(exp & {{(M-100){1'b0}}, {100{1'b1}}}));
      end
      idle_cycles(3);
      @(negedge clk);
      resetN = 1'b1;
      idle_cycles(2);
      blk[2] = rand_block();
      run_block("after_rst", blk[2], ref_enc(blk[2]));

      // Both buffers full: input blocked; an offered bit is dropped
      blk[0] = rand_block();
      blk[1] = rand_block();
      base = cap_q.size();
      send_bits(blk[0], N, e);
      send_bits(blk[1], N, e2);
      check("both_full_ready_low", M'(ready_in), M'(0));
      d_in = 1'b1;
      valid_in = 1'b1;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      d_in = 1'b0;
`ifdef FEC_ERR_EN
      check("err_drop_set", M'(err_drop), M'(1));
`endif
      wait_caps(base + 2*M, 800);
      idle_cycles(4);
      check("full_count", M'(cap_q.size() - base), M'(2*M));
      if (cap_q.size() - base >= 2*M) begin
         check("full_gaps", M'(gaps(base, 2*M)), M'(0));
         check("full_data0", burst(base, M), ref_enc(blk[0]));
         check("full_data1", burst(base + M, M), ref_enc(blk[1]));
      end
`ifdef FEC_ERR_EN
      check("err_drop_sticky", M'(err_drop), M'(1));
      resetN = 1'b0;
      #1;
      check("err_drop_cleared", M'(err_drop), M'(0));
      @(negedge clk);
      resetN = 1'b1;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
